// File: rtl/frame_pkg.sv
// Shared types and defaults for the frame writer.
// Pixel-to-word address helper lives here so all users agree on layout.
package frame_pkg;

  localparam int IMG_W_DEF      = 640;
  localparam int IMG_H_DEF      = 480;
  localparam int FIFO_DEPTH_DEF = 8;

  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 32;
  localparam int COORD_W = 13;
  localparam int WORD_W  = ADDR_W + DATA_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } wr_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_word_t;

  // Word address wraps modulo 2^ADDR_W by construction.
  function automatic logic [ADDR_W-1:0] word_addr(
    input logic [COORD_W-1:0] row,
    input logic [COORD_W-1:0] col,
    input int unsigned        line_words
  );
    logic [ADDR_W-1:0] r;
    logic [ADDR_W-1:0] lw;
    logic [ADDR_W-1:0] c;
    r  = ADDR_W'(row);
    lw = ADDR_W'(line_words);
    c  = ADDR_W'(col[COORD_W-1:2]);
    return (r * lw) + c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO.
// A push while full is accepted only when a pop frees a slot that cycle.
module sync_fifo #(
  parameter int   WIDTH = 49,
  parameter int   DEPTH = 8,
  localparam int  PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int  CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wr_en;
  logic             rd_en;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign wr_en = push_i && (!full_o || pop_i);
  assign rd_en = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/frame_writer.sv
// Packs in-frame pixels into 32-bit words and writes them to frame memory
// through a small word FIFO and a req/ack write engine.
module frame_writer
  import frame_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pix,
  input  logic [12:0] row,
  input  logic [12:0] col,
  output logic        mem_req,
  output logic [16:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        frame_done,
  output logic        overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LINE_WORDS = IMG_W / 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(IMG_H * IMG_W / 4 - 1);

  wr_state_e         state_q;
  wr_state_e         state_d;
  logic [31:0]       pack_q;
  logic [31:0]       pack_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              done_q;
  logic              done_d;

  logic              pix_valid;
  logic [1:0]        lane;
  logic              push;
  logic              pop;
  logic              push_ok;
  logic              more;
  mem_word_t         push_word;
  mem_word_t         head;
  logic [WORD_W-1:0] head_raw;
  logic              f_full;
  logic              f_empty;
  logic [CNT_W-1:0]  f_count;

  assign pix_valid = (row < COORD_W'(IMG_H))
                  && (col < COORD_W'(IMG_W));
  assign lane      = col[1:0];
  assign push      = pix_valid && (lane == 2'd3);

  assign push_word.addr = word_addr(row, col, LINE_WORDS);
  assign push_word.data = {pix, pack_q[23:0]};

  assign pop     = (state_q == ST_REQ) && mem_ack;
  assign push_ok = !f_full || pop;
  assign head    = head_raw;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_word),
    .pop_i   (pop),
    .data_o  (head_raw),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count)
  );

  always_comb begin
    pack_d = pack_q;
    if (pix_valid) begin
      unique case (lane)
        2'd0: pack_d = {24'h0, pix};
        2'd1: pack_d[15:8]  = pix;
        2'd2: pack_d[23:16] = pix;
        2'd3: pack_d[31:24] = pix;
      endcase
    end
  end

  // Start of frame clears the sticky flag; a drop can't coincide with it.
  always_comb begin
    ovf_d = ovf_q;
    if (pix_valid && row == '0 && col == '0) begin
      ovf_d = 1'b0;
    end else if (push && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  assign more = (f_count > CNT_W'(1)) || (push && push_ok);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!f_empty) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d = more ? ST_REQ : ST_IDLE;
          done_d  = (head.addr == LAST_ADDR);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pack_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pack_q  <= pack_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Gate with state so reset forces the bus to zero immediately.
  assign mem_req    = (state_q == ST_REQ);
  assign mem_addr   = mem_req ? head.addr : '0;
  assign mem_wdata  = mem_req ? head.data : '0;
  assign frame_done = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer.
// Stimulus feeds a byte-lane model; a monitor checks each accepted write.
module tb_frame_writer;

  localparam int W = 640;
  localparam int H = 480;
  localparam int D = 8;
  localparam int LAST = H * W / 4 - 1;

  localparam int ACK_ALWAYS = 0;
  localparam int ACK_NEVER  = 1;
  localparam int ACK_DELAY  = 2;
  localparam int ACK_RAND   = 3;

  typedef struct {
    logic [16:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pix = '0;
  logic [12:0] row = '1;
  logic [12:0] col = '1;
  logic        mem_req;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        frame_done;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  exp_t expq[$];
  logic [7:0] lanes [4];
  logic exp_ovf = 1'b0;

  int ack_mode = ACK_ALWAYS;
  int dly = 0;

  int writes = 0;
  int req_hi = 0;
  int fd_pulses = 0;
  logic [16:0] last_addr = '0;
  logic prev_hold = 1'b0;
  logic [16:0] hold_addr;
  logic [31:0] hold_data;
  logic fd_exp = 1'b0;

  frame_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix        (pix),
    .row        (row),
    .col        (col),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #20 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Memory responder
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        ACK_ALWAYS: mem_ack = 1'b1;
        ACK_NEVER:  mem_ack = 1'b0;
        ACK_DELAY: begin
          if (mem_ack) dly = 0;
          if (mem_req) dly++;
          mem_ack = (dly >= 4);
        end
        default: mem_ack = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Monitor: judges the handshake that the next rising edge will take.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
      fd_exp = 1'b0;
    end else begin
      logic fd_nxt;
      fd_nxt = 1'b0;
      chk("frame_done", int'(frame_done), int'(fd_exp));
      chk("overflow", int'(overflow), int'(exp_ovf));
      if (frame_done) fd_pulses++;
      if (mem_req) begin
        req_hi++;
        if (prev_hold) begin
          chk("hold_addr", int'(mem_addr), int'(hold_addr));
          chk("hold_data", int'(mem_wdata), int'(hold_data));
        end
        if (mem_ack) begin
          writes++;
          last_addr = mem_addr;
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write got addr %0h want none",
                     mem_addr);
          end else begin
            exp_t e;
            e = expq.pop_front();
            chk("wr_addr", int'(mem_addr), int'(e.addr));
            chk("wr_data", int'(mem_wdata), int'(e.data));
            fd_nxt = (int'(e.addr) == LAST);
          end
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          hold_addr = mem_addr;
          hold_data = mem_wdata;
        end
      end else begin
        if (prev_hold) begin
          checks++;
          errors++;
          $display("FAIL req_dropped got 0 want 1");
        end
        prev_hold = 1'b0;
      end
      fd_exp = fd_nxt;
    end
  end

  // Reference: in-frame pixels fill byte lanes; lane 3 completes a word.
  task automatic model_step();
    int r, c, ln;
    r = int'(row);
    c = int'(col);
    if (!rst_n || r >= H || c >= W) return;
    ln = c % 4;
    if (ln == 0) begin
      for (int i = 0; i < 4; i++) lanes[i] = 8'h0;
    end
    lanes[ln] = pix;
    if (r == 0 && c == 0) exp_ovf = 1'b0;
    if (ln == 3) begin
      if (expq.size() >= D) begin
        exp_ovf = 1'b1;
      end else begin
        exp_t e;
        e.addr = 17'((r * (W / 4) + c / 4) % 131072);
        e.data = {lanes[3], lanes[2], lanes[1], lanes[0]};
        expq.push_back(e);
      end
    end
  endtask

  task automatic cyc(input int r, input int c, input int p);
    @(posedge clk);
    #1;
    row = 13'(r);
    col = 13'(c);
    pix = 8'(p);
    @(negedge clk);
    #1;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(8191, 8191, 0);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((expq.size() != 0 || mem_req) && i < 300) begin
      idle(1);
      i++;
    end
    chk("drain_left", expq.size(), 0);
  endtask

  task automatic model_reset();
    expq.delete();
    for (int i = 0; i < 4; i++) lanes[i] = 8'h0;
    exp_ovf = 1'b0;
  endtask

  initial begin
    int w0, q0, f0, sr, sc, r, c, k;
    model_reset();

    // Reset state
    #5;
    chk("rst_req", int'(mem_req), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_data", int'(mem_wdata), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_ovf", int'(overflow), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // One word, ack tied high, latency
    ack_mode = ACK_ALWAYS;
    idle(2);
    w0 = writes;
    q0 = req_hi;
    cyc(0, 0, 8'h11);
    cyc(0, 1, 8'h22);
    cyc(0, 2, 8'h33);
    cyc(0, 3, 8'h44);
    idle(1);
    chk("lat_req_early", int'(mem_req), 0);
    idle(1);
    chk("lat_req", int'(mem_req), 1);
    chk("lat_addr", int'(mem_addr), 0);
    chk("lat_data", int'(mem_wdata), 32'h44332211);
    idle(1);
    chk("single_req_low", int'(mem_req), 0);
    idle(3);
    chk("single_writes", writes - w0, 1);
    chk("single_req_cyc", req_hi - q0, 1);

    // Delayed ack, data held until accepted
    ack_mode = ACK_DELAY;
    w0 = writes;
    q0 = req_hi;
    for (int i = 4; i < 8; i++) cyc(2, i, 8'hA0 + i);
    drain();
    chk("dly_writes", writes - w0, 1);
    chk("dly_req_cyc", req_hi - q0, 4);
    chk("dly_addr", int'(last_addr), 2 * (W / 4) + 1);

    // Out-of-frame coordinates are ignored
    ack_mode = ACK_ALWAYS;
    q0 = req_hi;
    cyc(0, 8188, 1);
    cyc(0, 8189, 2);
    cyc(0, 8190, 3);
    cyc(0, 8191, 4);
    for (int i = 0; i < 4; i++) cyc(480, i, 5 + i);
    for (int i = 0; i < 4; i++) cyc(8191, i, 9 + i);
    idle(4);
    chk("border_req", req_hi - q0, 0);

    // Stalled memory: FIFO fills, two words dropped
    ack_mode = ACK_NEVER;
    idle(1);
    for (int i = 0; i < 40; i++) cyc(1, i, int'($urandom_range(255, 0)));
    idle(2);
    chk("stall_ovf", int'(overflow), 1);
    w0 = writes;
    ack_mode = ACK_ALWAYS;
    drain();
    chk("stall_writes", writes - w0, 8);
    chk("stall_ovf_sticky", int'(overflow), 1);

    // End of frame
    f0 = fd_pulses;
    for (int rr = H - 2; rr < H; rr++) begin
      for (int cc = 0; cc < W; cc++) begin
        cyc(rr, cc, int'($urandom_range(255, 0)));
      end
    end
    drain();
    idle(2);
    chk("fd_pulses", fd_pulses - f0, 1);
    chk("fd_last_addr", int'(last_addr), LAST);

    // Randomized traffic with random ack
    ack_mode = ACK_RAND;
    sr = 0;
    sc = 0;
    for (int i = 0; i < 2500; i++) begin
      k = int'($urandom_range(99, 0));
      if (k < 75) begin
        r = sr;
        c = sc;
      end else if (k < 88) begin
        case ($urandom_range(2, 0))
          0: begin r = sr; c = 8190 + int'($urandom_range(1, 0)); end
          1: begin
            r = 480 + int'($urandom_range(7000, 0));
            c = int'($urandom_range(W - 1, 0));
          end
          default: begin
            r = int'($urandom_range(8191, 0));
            c = W + int'($urandom_range(7000, 0));
          end
        endcase
      end else begin
        r = int'($urandom_range(H - 1, 0));
        c = int'($urandom_range(W - 1, 0));
      end
      if (r < H && c < W) begin
        sr = r;
        sc = c + 1;
        if (sc == W) begin
          sc = 0;
          sr = (sr + 1) % H;
        end
      end
      cyc(r, c, int'($urandom_range(255, 0)));
    end
    ack_mode = ACK_ALWAYS;
    drain();

    // Reset during a pending request
    ack_mode = ACK_NEVER;
    for (int i = 0; i < 4; i++) cyc(3, i, 8'h50 + i);
    k = 0;
    while (!mem_req && k < 20) begin
      idle(1);
      k++;
    end
    chk("rst_mid_req_seen", int'(mem_req), 1);
    @(posedge clk);
    #7;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", int'(mem_req), 0);
    chk("rst_mid_addr", int'(mem_addr), 0);
    chk("rst_mid_data", int'(mem_wdata), 0);
    chk("rst_mid_ovf", int'(overflow), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ack_mode = ACK_ALWAYS;
    w0 = writes;
    q0 = req_hi;
    idle(10);
    chk("rst_no_retry_wr", writes - w0, 0);
    chk("rst_no_retry_req", req_hi - q0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
